// File: rtl/decred_serial_pkg.sv
// rtl/decred_serial_pkg.sv - shared rates, divider helpers, frame constants and TX state enum
package decred_serial_pkg;

  localparam int DEFAULT_CLK_RATE  = 50000000;
  localparam int DEFAULT_BAUD_RATE = 115200;

  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam int   BYTES_PER_NONCE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic int calc_div(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

  function automatic int calc_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - synchronous word FIFO; push and pop in one cycle are both honoured, even when full
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
  assign do_push    = push_i && (!full_o || do_pop);
  assign rdata_o    = mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && !do_push;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_uart_tx.sv
// rtl/nonce_uart_tx.sv - sends each queued golden nonce as four 8N1 bytes, little-endian, on tx
module nonce_uart_tx
  import decred_serial_pkg::*;
#(
  parameter int CLK_RATE   = DEFAULT_CLK_RATE,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_ready,
  input  logic [31:0] result_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int            DIV       = calc_div(CLK_RATE, BAUD_RATE);
  localparam int            CW        = calc_cnt_width(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  tx_state_e    state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]   bit_cnt_q;
  logic [1:0]   byte_idx_q;
  logic [31:0]  word_q;
  logic [7:0]   shift_q;
  logic         tx_q;
  logic         busy_q;

  logic [31:0]  fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         baud_tc;
  logic         last_byte;
  logic         going_idle;
  logic         active_d;

  nonce_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (result_ready),
    .wdata_i   (result_in),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .overflow_o(overflow)
  );

  assign baud_tc    = (baud_cnt_q == BAUD_LAST);
  assign last_byte  = (byte_idx_q == 2'(BYTES_PER_NONCE - 1));
  assign fifo_pop   = !fifo_empty &&
                      ((state_q == ST_IDLE) || (state_q == ST_STOP && baud_tc && last_byte));
  assign going_idle = (state_q == ST_STOP) && baud_tc && last_byte && fifo_empty;
  // Whether the FSM will be mid-frame after this edge; a queued word always implies it.
  assign active_d   = (state_q == ST_IDLE) ? !fifo_empty : !going_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      tx_q       <= STOP_BIT;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= active_d || result_ready || fifo_full;
      if (state_q == ST_IDLE) begin
        if (!fifo_empty) begin
          word_q     <= fifo_rdata;
          shift_q    <= fifo_rdata[7:0];
          byte_idx_q <= '0;
          baud_cnt_q <= '0;
          tx_q       <= START_BIT;
          state_q    <= ST_START;
        end
      end else if (!baud_tc) begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end else begin
        baud_cnt_q <= '0;
        case (state_q)
          ST_START: begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= STOP_BIT;
              state_q <= ST_STOP;
            end else begin
              tx_q      <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          ST_STOP: begin
            if (!last_byte) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              shift_q    <= word_q[{byte_idx_q + 2'd1, 3'b000} +: 8];
              tx_q       <= START_BIT;
              state_q    <= ST_START;
            end else if (!fifo_empty) begin
              word_q     <= fifo_rdata;
              shift_q    <= fifo_rdata[7:0];
              byte_idx_q <= '0;
              tx_q       <= START_BIT;
              state_q    <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_nonce_uart_tx.sv
// tb/tb_nonce_uart_tx.sv - scoreboard bench for nonce_uart_tx at the default and a reduced baud divisor
module tb_nonce_uart_tx;

  localparam int DIV_D = 434;
  localparam int DIV_S = 104;

  logic        clk = 1'b0;
  logic        rst_d, rst_s, rdy_d, rdy_s;
  logic [31:0] din_d, din_s;
  logic        tx_d, tx_s, busy_d, busy_s, ovf_d, ovf_s;

  always #5 clk = ~clk;

  nonce_uart_tx dut_d (
    .clk(clk), .reset(rst_d), .result_ready(rdy_d), .result_in(din_d),
    .tx(tx_d), .busy(busy_d), .overflow(ovf_d)
  );

  nonce_uart_tx #(.CLK_RATE(1000000), .BAUD_RATE(9600), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .reset(rst_s), .result_ready(rdy_s), .result_in(din_s),
    .tx(tx_s), .busy(busy_s), .overflow(ovf_s)
  );

  typedef struct {
    logic [31:0] nonce;
    logic [7:0]  b0, b1, b2, b3;
    bit          dropped;
  } vec_t;

  vec_t       vecs [6];
  int         cmp_cnt = 0;
  int         err_cnt = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  bit         sel = 1'b0;
  bit         mon_active = 1'b0;
  logic [7:0] exp_q [$];
  int         starts [$];
  logic       mon_tx, mon_rst, mon_busy;

  assign mon_tx   = sel ? tx_s   : tx_d;
  assign mon_rst  = sel ? rst_s  : rst_d;
  assign mon_busy = sel ? busy_s : busy_d;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ovf_s === 1'b1 || ovf_d === 1'b1) ovf_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] n);
    if (sel) begin rdy_s = 1'b1; din_s = n; end
    else     begin rdy_d = 1'b1; din_d = n; end
    @(negedge clk);
    rdy_s = 1'b0; rdy_d = 1'b0;
    din_s = $urandom; din_d = $urandom;
  endtask

  task automatic exp_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((mon_busy === 1'b1 || mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (mon_busy === 1'b1 || mon_active), 0);
    check({name, " bytes left"}, exp_q.size(), 0);
  endtask

  // Line decoder: one frame per falling edge, every bit expected to hold for exactly DIV samples.
  initial begin : monitor
    int         div, glitch;
    logic       bitv, stopv;
    logic [7:0] data, e;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!mon_rst && mon_tx === 1'b0) begin
        mon_active = 1'b1;
        div = sel ? DIV_S : DIV_D;
        glitch = 0; aborted = 1'b0; data = '0; stopv = 1'b0; bitv = 1'b0;
        starts.push_back(cyc);
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int s = 0; s < div && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (mon_rst) aborted = 1'b1;
            else if (s == 0) bitv = mon_tx;
            else if (mon_tx !== bitv) glitch++;
          end
          if (b >= 1 && b <= 8) data[b-1] = bitv;
          if (b == 9) stopv = bitv;
        end
        if (!aborted) begin
          check("bit stability", glitch, 0);
          check("stop bit", stopv, 1);
          if (exp_q.size() == 0) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL unexpected byte: got %0h, expected none", data);
          end else begin
            e = exp_q.pop_front();
            check("byte value", data, e);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    int c_set, c1, n, bad;
    rst_d = 1'b1; rst_s = 1'b1; rdy_d = 1'b0; rdy_s = 1'b0; din_d = '0; din_s = '0;
    vecs[0] = '{32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b0};
    vecs[1] = '{32'h0F1E2D3C, 8'h3C, 8'h2D, 8'h1E, 8'h0F, 1'b0};
    vecs[2] = '{32'h55AA33CC, 8'hCC, 8'h33, 8'hAA, 8'h55, 1'b0};
    vecs[3] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 1'b0};
    vecs[4] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 1'b0};
    vecs[5] = '{32'h13579BDF, 8'hDF, 8'h9B, 8'h57, 8'h13, 1'b1};

    @(negedge clk); @(negedge clk);
    check("reset tx_d", tx_d, 1);     check("reset busy_d", busy_d, 0); check("reset ovf_d", ovf_d, 0);
    check("reset tx_s", tx_s, 1);     check("reset busy_s", busy_s, 0); check("reset ovf_s", ovf_s, 0);
    rst_d = 1'b0; rst_s = 1'b0;
    @(negedge clk);

    // Single nonce at the default divisor.
    sel = 1'b0; starts.delete();
    exp_bytes(8'h78, 8'h56, 8'h34, 8'h12);
    c_set = cyc;
    push(32'h12345678);
    check("busy after E0", busy_d, 1);
    check("tx idle after E0", tx_d, 1);
    @(negedge clk);
    check("tx low after E1", tx_d, 0);
    c1 = cyc;
    check("E1 cycle", c1, c_set + 2);
    n = 0;
    while (busy_d === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check("busy fall delay", cyc - c1, 17360);
    wait_done("single nonce", 2000);

    // Zeros then ones, 10 cycles apart, reduced divisor: no gap between nonces.
    sel = 1'b1; starts.delete();
    exp_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    exp_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push(32'h00000000);
    repeat (9) @(negedge clk);
    push(32'hFFFFFFFF);
    wait_done("zeros ones", 12000);
    check("zeros ones starts", starts.size(), 8);
    for (int i = 1; i < 8 && i < starts.size(); i++) check("zeros ones gap", starts[i] - starts[i-1], 1040);

    // Six back-to-back pushes, then a push landing on the STOP->START pop while full.
    starts.delete(); ovf_cnt = 0;
    c_set = cyc;
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].dropped) exp_bytes(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      push(vecs[i].nonce);
    end
    check("overflow after F", ovf_s, 1);
    @(negedge clk);
    check("overflow one cycle", ovf_s, 0);
    c1 = c_set + 2;
    while (cyc < c1 + 4159) @(negedge clk);
    exp_bytes(8'hE0, 8'hAC, 8'h68, 8'h24);
    push(32'h2468ACE0);
    check("no overflow on push+pop", ovf_s, 0);
    wait_done("burst", 30000);
    check("overflow pulse count", ovf_cnt, 1);
    check("burst starts", starts.size(), 24);
    if (starts.size() > 0) check("burst first start", starts[0], c1);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 1040) bad++;
    check("burst gaps", bad, 0);

    // Reset in the middle of byte 2 data bits with two nonces still queued.
    starts.delete();
    exp_q.push_back(8'hE1); exp_q.push_back(8'hC3);
    c_set = cyc;
    push(32'h5A00C3E1); push(32'h0BADF00D); push(32'hCAFEF00D);
    c1 = c_set + 2;
    while (cyc < c1 + 2584) @(negedge clk);
    check("tx low before reset", tx_s, 0);
    rst_s = 1'b1;
    #1;
    check("tx forced high", tx_s, 1);
    check("busy cleared", busy_s, 0);
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    n = 0;
    repeat (1500) begin @(negedge clk); if (tx_s !== 1'b1) n++; end
    check("quiet after reset", n, 0);
    check("busy after reset", busy_s, 0);
    check("frames before reset", starts.size(), 3);
    check("reset bytes left", exp_q.size(), 0);
    exp_bytes(8'hFE, 8'hCA, 8'h0D, 8'h60);
    push(32'h600DCAFE);
    wait_done("after reset", 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
